esm_issue_scheduler: RTL and testbench

Slot allocator and issue scheduler for the ESM instruction buffer. It owns the per-slot state of the `bs`-entry buffer. It hands out the `buffer_index` for each incoming instruction and drives `valid_entries` into the dependency-analysis core. It takes `independent_instr` back and issues ready slots one at a time over a valid/ready port, freeing each slot when its completion is reported.

---
 rtl/esm_issue_scheduler.sv | 162 ++++++++++++++++
 tb/tb_esm_issue_scheduler.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/esm_issue_scheduler.sv
// Slot allocator and single-port issue scheduler for the ESM instruction buffer.
// Define ESM_SCHED_RR_EN for round-robin issue selection; otherwise lowest candidate index wins.
module esm_issue_scheduler #(
    parameter  int bs = 16,
    localparam int IW = $clog2(bs)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alloc_req,
    output logic          alloc_gnt,
    output logic [IW-1:0] alloc_index,
    output logic [0:bs-1] valid_entries,
    input  logic [0:bs-1] independent_instr,
    output logic          issue_valid,
    output logic [IW-1:0] issue_index,
    input  logic          issue_ready,
    input  logic          cmpl_valid,
    input  logic [IW-1:0] cmpl_index,
    output logic          cmpl_err,
    output logic          full,
    output logic          empty,
    output logic [IW:0]   occupancy
);

    typedef enum logic [1:0] {
        S_FREE    = 2'd0,
        S_WAITING = 2'd1,
        S_ISSUED  = 2'd2
    } slot_state_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } fsm_e;

    slot_state_e   slot_q [bs];
    slot_state_e   slot_d [bs];
    fsm_e          fsm_q, fsm_d;
    logic [IW-1:0] issue_index_q, issue_index_d;
    logic [0:bs-1] valid_entries_q, valid_entries_d;
    logic [IW:0]   occupancy_q, occupancy_d;
    logic          cmpl_err_q, cmpl_err_d;

    logic [0:bs-1] cand;
    logic          handshake;
    logic          cmpl_legal;
    logic          sel_found;
    logic [IW-1:0] sel_index;
    logic [IW-1:0] search_start;
    logic [IW-1:0] probe;

    assign full      = (occupancy_q == (IW+1)'(bs));
    assign empty     = (occupancy_q == '0);
    assign alloc_gnt = alloc_req & ~full;

    // Lowest FREE slot from registered state; a slot freed this cycle is only visible next cycle.
    always_comb begin
        alloc_index = '0;
        for (int i = bs - 1; i >= 0; i--) begin
            if (slot_q[i] == S_FREE) alloc_index = IW'(i);
        end
    end

    assign handshake  = (fsm_q == ST_OFFER) && issue_ready;
    assign cmpl_legal = cmpl_valid && (slot_q[cmpl_index] == S_ISSUED);

    always_comb begin
        for (int i = 0; i < bs; i++) begin
            cand[i] = (slot_q[i] == S_WAITING) && independent_instr[i]
                      && !((fsm_q == ST_OFFER) && (issue_index_q == IW'(i)));
        end
    end

`ifdef ESM_SCHED_RR_EN
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;

    // The pointer moves past a slot the moment it is accepted, so a back-to-back reload already sees it.
    assign rr_ptr_d     = handshake ? issue_index_q + 1'b1 : rr_ptr_q;
    assign search_start = rr_ptr_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rr_ptr_q <= '0;
        else      rr_ptr_q <= rr_ptr_d;
    end
`else
    assign search_start = '0;
`endif

    // Scan starting at search_start; the IW-bit sum wraps from bs-1 back to 0.
    always_comb begin
        sel_found = 1'b0;
        sel_index = '0;
        probe     = '0;
        for (int k = 0; k < bs; k++) begin
            probe = search_start + IW'(k);
            if (!sel_found && cand[probe]) begin
                sel_found = 1'b1;
                sel_index = probe;
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        fsm_d         = fsm_q;
        issue_index_d = issue_index_q;
        unique case (fsm_q)
            ST_IDLE: begin
                if (sel_found) begin
                    fsm_d         = ST_OFFER;
                    issue_index_d = sel_index;
                end
            end
            ST_OFFER: begin
                if (issue_ready) begin
                    if (sel_found) issue_index_d = sel_index;
                    else           fsm_d         = ST_IDLE;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    // Alloc, issue and completion always touch three different slots (FREE, WAITING, ISSUED).
    always_comb begin
        slot_d = slot_q;
        if (alloc_gnt)  slot_d[alloc_index]   = S_WAITING;
        if (handshake)  slot_d[issue_index_q] = S_ISSUED;
        if (cmpl_legal) slot_d[cmpl_index]    = S_FREE;
        for (int i = 0; i < bs; i++) begin
            valid_entries_d[i] = (slot_d[i] != S_FREE);
        end
        occupancy_d = occupancy_q + (IW+1)'(alloc_gnt) - (IW+1)'(cmpl_legal);
        cmpl_err_d  = cmpl_valid & ~cmpl_legal;
    end

    // NOTE: the slot-state array is control state, not data storage, so it must be reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_q          <= '{default: S_FREE};
            fsm_q           <= ST_IDLE;
            issue_index_q   <= '0;
            valid_entries_q <= '0;
            occupancy_q     <= '0;
            cmpl_err_q      <= 1'b0;
        end else begin
            slot_q          <= slot_d;
            fsm_q           <= fsm_d;
            issue_index_q   <= issue_index_d;
            valid_entries_q <= valid_entries_d;
            occupancy_q     <= occupancy_d;
            cmpl_err_q      <= cmpl_err_d;
        end
    end

    assign issue_valid   = (fsm_q == ST_OFFER);
    assign issue_index   = issue_index_q;
    assign valid_entries = valid_entries_q;
    assign occupancy     = occupancy_q;
    assign cmpl_err      = cmpl_err_q;

endmodule

// File: tb/tb_esm_issue_scheduler.sv
// Self-checking bench for esm_issue_scheduler: directed scenarios plus a randomized run
// against a slot-level reference model. Honours ESM_SCHED_RR_EN the same way as the design.
module tb_esm_issue_scheduler;

    localparam int BS = 16;
    localparam int IW = $clog2(BS);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          alloc_req = 1'b0;
    logic          alloc_gnt;
    logic [IW-1:0] alloc_index;
    logic [0:BS-1] valid_entries;
    logic [0:BS-1] independent_instr = '0;
    logic          issue_valid;
    logic [IW-1:0] issue_index;
    logic          issue_ready = 1'b0;
    logic          cmpl_valid = 1'b0;
    logic [IW-1:0] cmpl_index = '0;
    logic          cmpl_err;
    logic          full;
    logic          empty;
    logic [IW:0]   occupancy;

    int checks = 0;
    int errors = 0;

    // Reference model: 0 = FREE, 1 = WAITING, 2 = ISSUED.
    int ms [BS];
    int m_occ;
    bit m_off;
    int m_idx;
    int m_ptr;
    bit m_err;

    esm_issue_scheduler #(.bs(BS)) dut (
        .clk               (clk),
        .rst               (rst),
        .alloc_req         (alloc_req),
        .alloc_gnt         (alloc_gnt),
        .alloc_index       (alloc_index),
        .valid_entries     (valid_entries),
        .independent_instr (independent_instr),
        .issue_valid       (issue_valid),
        .issue_index       (issue_index),
        .issue_ready       (issue_ready),
        .cmpl_valid        (cmpl_valid),
        .cmpl_index        (cmpl_index),
        .cmpl_err          (cmpl_err),
        .full              (full),
        .empty             (empty),
        .occupancy         (occupancy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic m_reset();
        for (int i = 0; i < BS; i++) ms[i] = 0;
        m_occ = 0;
        m_off = 1'b0;
        m_idx = 0;
        m_ptr = 0;
        m_err = 1'b0;
    endtask

    function automatic int m_lowest_free();
        for (int i = 0; i < BS; i++) if (ms[i] == 0) return i;
        return -1;
    endfunction

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic m_update();
        int  f;
        bit  gnt, legal, hs, found;
        int  start, sel, old_idx;
        f       = m_lowest_free();
        gnt     = alloc_req && (m_occ < BS);
        legal   = cmpl_valid && (ms[int'(cmpl_index)] == 2);
        hs      = m_off && issue_ready;
        old_idx = m_idx;
`ifdef ESM_SCHED_RR_EN
        start = hs ? (old_idx + 1) % BS : m_ptr;
`else
        start = 0;
`endif
        found = 1'b0;
        sel   = 0;
        for (int k = 0; k < BS; k++) begin
            int j;
            j = (start + k) % BS;
            if (!found && ms[j] == 1 && independent_instr[j] && !(m_off && old_idx == j)) begin
                found = 1'b1;
                sel   = j;
            end
        end
        if (!(m_off && !issue_ready)) begin
            if (found) begin
                m_off = 1'b1;
                m_idx = sel;
            end else begin
                m_off = 1'b0;
            end
        end
        if (hs) begin
            ms[old_idx] = 2;
            m_ptr       = (old_idx + 1) % BS;
        end
        if (gnt) ms[f] = 1;
        if (legal) ms[int'(cmpl_index)] = 0;
        m_occ = m_occ + int'(gnt) - int'(legal);
        m_err = cmpl_valid && !legal;
    endtask

    task automatic tick();
        m_update();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_inputs();
        alloc_req         = 1'b0;
        independent_instr = '0;
        issue_ready       = 1'b0;
        cmpl_valid        = 1'b0;
        cmpl_index        = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drop_inputs();
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL reset_issue_valid: got %b want 0", issue_valid); end
        checks++; if (issue_index !== '0) begin errors++; $display("FAIL reset_issue_index: got %0d want 0", issue_index); end
        checks++; if (valid_entries !== '0) begin errors++; $display("FAIL reset_valid_entries: got %h want 0", valid_entries); end
        checks++; if (occupancy !== '0) begin errors++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
        checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_flags: got empty=%b full=%b want 1/0", empty, full); end
        checks++; if (cmpl_err !== 1'b0) begin errors++; $display("FAIL reset_cmpl_err: got %b want 0", cmpl_err); end
        checks++; if (alloc_gnt !== 1'b0 || alloc_index !== '0) begin errors++; $display("FAIL reset_alloc: got gnt=%b idx=%0d want 0/0", alloc_gnt, alloc_index); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < BS; i++) begin
            alloc_req = 1'b1;
            #1;
            checks++; if (alloc_gnt !== 1'b1 || alloc_index !== IW'(i)) begin errors++; $display("FAIL fill_grant[%0d]: got gnt=%b idx=%0d want 1/%0d", i, alloc_gnt, alloc_index, i); end
            checks++; if (valid_entries[i] !== 1'b0) begin errors++; $display("FAIL fill_valid_pre[%0d]: got %b want 0", i, valid_entries[i]); end
            tick();
            checks++; if (valid_entries[i] !== 1'b1) begin errors++; $display("FAIL fill_valid_post[%0d]: got %b want 1", i, valid_entries[i]); end
        end
        checks++; if (full !== 1'b1 || empty !== 1'b0 || occupancy !== (IW+1)'(BS)) begin errors++; $display("FAIL fill_full: got full=%b empty=%b occ=%0d want 1/0/%0d", full, empty, occupancy, BS); end
        alloc_req = 1'b1;
        #1;
        checks++; if (alloc_gnt !== 1'b0) begin errors++; $display("FAIL fill_17th_gnt: got %b want 0", alloc_gnt); end
        tick();
        alloc_req = 1'b0;
        checks++; if (occupancy !== (IW+1)'(BS)) begin errors++; $display("FAIL fill_17th_occ: got %0d want %0d", occupancy, BS); end
    endtask

    task automatic test_issue_order();
        int seq [3] = '{3, 5, 9};
        independent_instr    = '0;
        independent_instr[3] = 1'b1;
        independent_instr[5] = 1'b1;
        independent_instr[9] = 1'b1;
        issue_ready = 1'b1;
        #1;
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL order_latency: got valid=%b want 0", issue_valid); end
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++; if (issue_valid !== 1'b1 || issue_index !== IW'(seq[k])) begin errors++; $display("FAIL order_issue[%0d]: got valid=%b idx=%0d want 1/%0d", k, issue_valid, issue_index, seq[k]); end
            tick();
        end
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL order_idle: got valid=%b want 0", issue_valid); end
        drop_inputs();
    endtask

    task automatic test_rr_order();
        int rel [3] = '{3, 5, 9};
        int first, second;
        for (int k = 0; k < 3; k++) begin
            cmpl_valid = 1'b1;
            cmpl_index = IW'(rel[k]);
            tick();
        end
        cmpl_valid = 1'b0;
        checks++; if (occupancy !== (IW+1)'(BS - 3)) begin errors++; $display("FAIL rr_release_occ: got %0d want %0d", occupancy, BS - 3); end
        for (int k = 0; k < 3; k++) begin
            alloc_req = 1'b1;
            #1;
            checks++; if (alloc_gnt !== 1'b1 || alloc_index !== IW'(rel[k])) begin errors++; $display("FAIL rr_realloc[%0d]: got gnt=%b idx=%0d want 1/%0d", k, alloc_gnt, alloc_index, rel[k]); end
            tick();
        end
        alloc_req = 1'b0;
        independent_instr    = '0;
        independent_instr[5] = 1'b1;
        issue_ready = 1'b1;
        tick();
        checks++; if (issue_valid !== 1'b1 || issue_index !== IW'(5)) begin errors++; $display("FAIL rr_issue5: got valid=%b idx=%0d want 1/5", issue_valid, issue_index); end
        independent_instr = '0;
        tick();
`ifdef ESM_SCHED_RR_EN
        first  = 7;
        second = 2;
`else
        first  = 2;
        second = 7;
`endif
        independent_instr[2] = 1'b1;
        independent_instr[7] = 1'b1;
        tick();
        checks++; if (issue_valid !== 1'b1 || issue_index !== IW'(first)) begin errors++; $display("FAIL rr_first: got valid=%b idx=%0d want 1/%0d", issue_valid, issue_index, first); end
        tick();
        checks++; if (issue_valid !== 1'b1 || issue_index !== IW'(second)) begin errors++; $display("FAIL rr_second: got valid=%b idx=%0d want 1/%0d", issue_valid, issue_index, second); end
        independent_instr = '0;
        tick();
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL rr_idle: got valid=%b want 0", issue_valid); end
        drop_inputs();
    endtask

    task automatic test_hold();
        independent_instr[4] = 1'b1;
        issue_ready = 1'b0;
        tick();
        independent_instr = '0;
        checks++; if (issue_valid !== 1'b1 || issue_index !== IW'(4)) begin errors++; $display("FAIL hold_offer: got valid=%b idx=%0d want 1/4", issue_valid, issue_index); end
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++; if (issue_valid !== 1'b1 || issue_index !== IW'(4)) begin errors++; $display("FAIL hold_stable[%0d]: got valid=%b idx=%0d want 1/4", c, issue_valid, issue_index); end
        end
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL hold_accept: got valid=%b want 0", issue_valid); end
    endtask

    task automatic test_full_cmpl();
        independent_instr[6] = 1'b1;
        issue_ready = 1'b1;
        tick();
        independent_instr = '0;
        tick();
        issue_ready = 1'b0;
        cmpl_valid = 1'b1;
        cmpl_index = IW'(6);
        alloc_req  = 1'b1;
        #1;
        checks++; if (alloc_gnt !== 1'b0 || full !== 1'b1) begin errors++; $display("FAIL fullcmpl_nogrant: got gnt=%b full=%b want 0/1", alloc_gnt, full); end
        tick();
        cmpl_valid = 1'b0;
        #1;
        checks++; if (alloc_gnt !== 1'b1 || alloc_index !== IW'(6) || occupancy !== (IW+1)'(BS - 1)) begin errors++; $display("FAIL fullcmpl_grant6: got gnt=%b idx=%0d occ=%0d want 1/6/%0d", alloc_gnt, alloc_index, occupancy, BS - 1); end
        tick();
        alloc_req = 1'b0;
        checks++; if (occupancy !== (IW+1)'(BS) || full !== 1'b1 || valid_entries[6] !== 1'b1) begin errors++; $display("FAIL fullcmpl_refill: got occ=%0d full=%b v6=%b want %0d/1/1", occupancy, full, valid_entries[6], BS); end
    endtask

    task automatic test_cmpl_err();
        logic [0:BS-1] saved;
        cmpl_valid = 1'b1;
        cmpl_index = IW'(2);
        tick();
        checks++; if (cmpl_err !== 1'b0 || occupancy !== (IW+1)'(BS - 1)) begin errors++; $display("FAIL err_legal: got err=%b occ=%0d want 0/%0d", cmpl_err, occupancy, BS - 1); end
        saved = valid_entries;
        tick();
        checks++; if (cmpl_err !== 1'b1) begin errors++; $display("FAIL err_free_pulse: got %b want 1", cmpl_err); end
        checks++; if (occupancy !== (IW+1)'(BS - 1) || valid_entries !== saved) begin errors++; $display("FAIL err_free_nochange: got occ=%0d ve=%h want %0d/%h", occupancy, valid_entries, BS - 1, saved); end
        cmpl_valid = 1'b0;
        tick();
        checks++; if (cmpl_err !== 1'b0) begin errors++; $display("FAIL err_pulse_width: got %b want 0", cmpl_err); end
        independent_instr[8] = 1'b1;
        tick();
        cmpl_valid = 1'b1;
        cmpl_index = IW'(8);
        tick();
        checks++; if (cmpl_err !== 1'b1 || valid_entries[8] !== 1'b1) begin errors++; $display("FAIL err_offered: got err=%b v8=%b want 1/1", cmpl_err, valid_entries[8]); end
        checks++; if (issue_valid !== 1'b1 || issue_index !== IW'(8)) begin errors++; $display("FAIL err_offer_kept: got valid=%b idx=%0d want 1/8", issue_valid, issue_index); end
        cmpl_valid = 1'b0;
        independent_instr = '0;
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
    endtask

    task automatic test_reset_mid_offer();
        independent_instr[10] = 1'b1;
        tick();
        checks++; if (issue_valid !== 1'b1 || issue_index !== IW'(10)) begin errors++; $display("FAIL midrst_offer: got valid=%b idx=%0d want 1/10", issue_valid, issue_index); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (issue_valid !== 1'b0 || issue_index !== '0) begin errors++; $display("FAIL midrst_issue: got valid=%b idx=%0d want 0/0", issue_valid, issue_index); end
        checks++; if (occupancy !== '0 || valid_entries !== '0) begin errors++; $display("FAIL midrst_state: got occ=%0d ve=%h want 0/0", occupancy, valid_entries); end
        checks++; if (empty !== 1'b1 || full !== 1'b0 || cmpl_err !== 1'b0) begin errors++; $display("FAIL midrst_flags: got empty=%b full=%b err=%b want 1/0/0", empty, full, cmpl_err); end
        drop_inputs();
        m_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_random();
        logic [0:BS-1] exp_ve;
        int issued [$];
        int f;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            alloc_req         = ($urandom_range(0, 99) < 55);
            independent_instr = BS'($urandom);
            issue_ready       = ($urandom_range(0, 99) < 60);
            cmpl_valid        = ($urandom_range(0, 99) < 45);
            issued.delete();
            for (int i = 0; i < BS; i++) if (ms[i] == 2) issued.push_back(i);
            if (issued.size() > 0 && $urandom_range(0, 99) < 85)
                cmpl_index = IW'(issued[$urandom_range(0, issued.size() - 1)]);
            else
                cmpl_index = IW'($urandom_range(0, BS - 1));
            #1;
            for (int i = 0; i < BS; i++) exp_ve[i] = (ms[i] != 0);
            f = m_lowest_free();
            checks++; if (alloc_gnt !== (alloc_req && m_occ < BS)) begin errors++; $display("FAIL rnd_gnt@%0d: got %b want %b", cyc, alloc_gnt, (alloc_req && m_occ < BS)); end
            if (f >= 0) begin
                checks++; if (alloc_index !== IW'(f)) begin errors++; $display("FAIL rnd_alloc_index@%0d: got %0d want %0d", cyc, alloc_index, f); end
            end
            checks++; if (issue_valid !== m_off) begin errors++; $display("FAIL rnd_issue_valid@%0d: got %b want %b", cyc, issue_valid, m_off); end
            if (m_off) begin
                checks++; if (issue_index !== IW'(m_idx)) begin errors++; $display("FAIL rnd_issue_index@%0d: got %0d want %0d", cyc, issue_index, m_idx); end
            end
            checks++; if (valid_entries !== exp_ve) begin errors++; $display("FAIL rnd_valid_entries@%0d: got %h want %h", cyc, valid_entries, exp_ve); end
            checks++; if (occupancy !== (IW+1)'(m_occ)) begin errors++; $display("FAIL rnd_occupancy@%0d: got %0d want %0d", cyc, occupancy, m_occ); end
            checks++; if (full !== (m_occ == BS) || empty !== (m_occ == 0)) begin errors++; $display("FAIL rnd_flags@%0d: got full=%b empty=%b occ_model=%0d", cyc, full, empty, m_occ); end
            checks++; if (cmpl_err !== m_err) begin errors++; $display("FAIL rnd_cmpl_err@%0d: got %b want %b", cyc, cmpl_err, m_err); end
            tick();
        end
        drop_inputs();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_issue_order();
        test_rr_order();
        test_hold();
        test_full_cmpl();
        test_cmpl_err();
        test_reset_mid_offer();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
